// File: rtl/setpoint_button_ctrl_pkg.sv
// Shared definitions for the altitude setpoint conditioner.
// The setpoint constants are also consumed by the PID stage and the VGA overlay,
// so they live here rather than as parameters of the controller.
package setpoint_button_ctrl_pkg;

  localparam int SP_W = 15;
  localparam logic signed [SP_W-1:0] SP_RESET = 15'sd240;
  localparam logic signed [SP_W-1:0] SP_MIN   = 15'sd1;
  localparam logic signed [SP_W-1:0] SP_MAX   = 15'sd446;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} state_t;
  typedef enum logic {UP, DOWN} dir_t;

  // UP moves the line towards the top of the screen (smaller Y). One guard bit
  // keeps the intermediate sum from wrapping before it is clamped.
  function automatic logic signed [SP_W-1:0] step_setpoint(
    input logic signed [SP_W-1:0] sp,
    input dir_t                   dir,
    input int                     step
  );
    logic signed [SP_W:0] wide;
    logic signed [SP_W:0] delta;
    logic signed [SP_W:0] lo;
    logic signed [SP_W:0] hi;
    delta = (SP_W+1)'(step);
    lo    = $signed({SP_MIN[SP_W-1], SP_MIN});
    hi    = $signed({SP_MAX[SP_W-1], SP_MAX});
    if (dir == UP) begin
      wide = $signed({sp[SP_W-1], sp}) - delta;
      if (wide < lo) return SP_MIN;
    end else begin
      wide = $signed({sp[SP_W-1], sp}) + delta;
      if (wide > hi) return SP_MAX;
    end
    return wide[SP_W-1:0];
  endfunction

endpackage

// File: rtl/setpoint_button_ctrl_if.sv
// Button/setpoint bundle between the board-level buttons and the setpoint
// controller. The master side drives the raw active-low buttons.
interface setpoint_button_ctrl_if;
  import setpoint_button_ctrl_pkg::*;

  logic                   up_n;
  logic                   down_n;
  logic signed [SP_W-1:0] setpoint;
  logic                   sp_changed;
  logic                   up_held;
  logic                   down_held;

  modport master (
    output up_n, down_n,
    input  setpoint, sp_changed, up_held, down_held
  );

  modport slave (
    input  up_n, down_n,
    output setpoint, sp_changed, up_held, down_held
  );
endinterface

// File: rtl/setpoint_button_ctrl_button_debounce.sv
// Two-flop synchroniser plus level debouncer for one active-low push button.
// The output is the accepted (stable) pressed level, active-high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn_n,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  assign pressed = ~sync2;

  // Synchroniser flops idle at 1 so a released button looks released from reset.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with the stable one for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= pressed;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/setpoint_button_ctrl.sv
// Altitude setpoint controller: debounced up/down buttons step a clamped
// signed setpoint register. Auto-repeat while held is enabled by defining
// SETPOINT_AUTOREPEAT_EN; otherwise each press gives exactly one step.
module setpoint_button_ctrl
  import setpoint_button_ctrl_pkg::*;
#(
  parameter int STEP            = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic              CLK,
  input logic              rst,
  setpoint_button_ctrl_if.slave bus
);

  logic                   up_held;
  logic                   down_held;
  state_t                 state;
  state_t                 state_next;
  logic                   step_req;
  dir_t                   step_dir;
  logic signed [SP_W-1:0] sp_q;
  logic signed [SP_W-1:0] sp_stepped;
  logic                   changed_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .CLK   (CLK),
    .rst   (rst),
    .btn_n (bus.up_n),
    .level (up_held)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .CLK   (CLK),
    .rst   (rst),
    .btn_n (bus.down_n),
    .level (down_held)
  );

`ifdef SETPOINT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  dir_t             dir;
  dir_t             dir_next;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_next;
  logic             abort;

  // State, latched direction and repeat counter registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= UP;
      rpt_cnt <= '0;
    end else begin
      state   <= state_next;
      dir     <= dir_next;
      rpt_cnt <= rpt_cnt_next;
    end
  end

  // Leave DELAY/REPEAT when our button lets go or the opposite one joins in.
  always_comb begin
    state_next   = state;
    dir_next     = dir;
    rpt_cnt_next = rpt_cnt;
    step_req     = 1'b0;
    step_dir     = dir;
    abort        = (dir == UP) ? (!up_held || down_held) : (!down_held || up_held);
    case (state)
      IDLE: begin
        if (up_held ^ down_held) begin
          step_req     = 1'b1;
          step_dir     = up_held ? UP : DOWN;
          dir_next     = up_held ? UP : DOWN;
          rpt_cnt_next = '0;
          state_next   = DELAY;
        end
      end
      DELAY: begin
        if (abort) begin
          rpt_cnt_next = '0;
          state_next   = IDLE;
        end else if (rpt_cnt == DELAY_LAST) begin
          step_req     = 1'b1;
          rpt_cnt_next = '0;
          state_next   = REPEAT;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      REPEAT: begin
        if (abort) begin
          rpt_cnt_next = '0;
          state_next   = IDLE;
        end else if (rpt_cnt == PERIOD_LAST) begin
          step_req     = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        rpt_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end
`else
  // State register for the one-step-per-press variant.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // One step on the press, then wait in HELD until both buttons are up.
  always_comb begin
    state_next = state;
    step_req   = 1'b0;
    step_dir   = up_held ? UP : DOWN;
    case (state)
      IDLE: begin
        if (up_held ^ down_held) begin
          step_req   = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (!up_held && !down_held) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
`endif

  assign sp_stepped = step_setpoint(sp_q, step_dir, STEP);

  // Setpoint register; a step that clamps onto the current value is not a change.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sp_q      <= SP_RESET;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (step_req && (sp_stepped != sp_q)) begin
        sp_q      <= sp_stepped;
        changed_q <= 1'b1;
      end
    end
  end

  assign bus.setpoint   = sp_q;
  assign bus.sp_changed = changed_q;
  assign bus.up_held    = up_held;
  assign bus.down_held  = down_held;

endmodule
